delay_addr_gen: RTL and testbench
=================================

# delay_addr_gen

Address and strobe generator that drives the dual-port sample RAM of the delayed-signal path. At a programmable sample rate it issues one write per sample at a circular write pointer and, once enough history exists, a read at the write pointer minus a programmable offset. It also produces a valid strobe aligned with the RAM's registered read data. It sits directly upstream of the dual-port RAM; its outputs connect straight to that RAM's write/read enables and addresses.

## Interface
- ADDR_WIDTH, 8: RAM address width; buffer depth = 2**ADDR_WIDTH.
- DIV_WIDTH, 16: width of the sample-rate divider.

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low freezes generation.
- clear  in  1  synchronous flush of pointers and history; priority over en.
- div  in  DIV_WIDTH  sample period minus one, in clk cycles (0 = sample every cycle).
- offset  in  ADDR_WIDTH  read delay in samples (0 = full-buffer delay of 2**ADDR_WIDTH).
- wr_en  out  1  one-cycle write strobe to RAM.
- wr_addr  out  ADDR_WIDTH  RAM write address.
- rd_en  out  1  one-cycle read strobe to RAM.
- rd_addr  out  ADDR_WIDTH  RAM read address.
- dout_valid  out  1  high in the cycle RAM dout holds the sample read by the previous rd_en.
- primed  out  1  enough history written for the current offset.

## Operation
- States: IDLE, FILL, RUN.
- IDLE: entered on reset, on clear, and whenever en=0. Divider counter is held at 0. No strobes. Pointers and the history count are retained, except that clear zeroes them.
- IDLE -> FILL on en=1 when count < need; IDLE -> RUN on en=1 when count >= need.
- need = offset, or 2**ADDR_WIDTH when offset = 0.
- Divider: cnt counts 0..div. tick = en & (cnt == div). cnt returns to 0 on tick.
- Each tick:
  - wr_en pulses with wr_addr = wptr.
  - wptr increments, wrapping from 2**ADDR_WIDTH-1 to 0.
  - count (ADDR_WIDTH+1 bits) increments, saturating at 2**ADDR_WIDTH.
- Read on a tick only in RUN, i.e. when count before the tick is >= need:
  - rd_en pulses with rd_addr = (wptr - offset) mod 2**ADDR_WIDTH, using the pre-increment wptr.
- Offset = 0 reads the address being written in the same cycle. The RAM returns the old contents, giving a delay of 2**ADDR_WIDTH samples.
- FILL -> RUN when count >= need. RUN -> FILL when offset changes so that count < need; this is only possible before count saturates.
- offset and div are sampled on every cycle. A change takes effect on the next tick evaluation. No pointer is disturbed by the change.
- primed = (state == RUN).
- clear: wptr=0, count=0, cnt=0, state=IDLE, strobes deasserted next cycle. clear together with a tick: clear wins and no strobe is issued.

## Timing
- Reset values: wr_en=0, rd_en=0, wr_addr=0, rd_addr=0, dout_valid=0, primed=0. Internally wptr=0, count=0, cnt=0, state=IDLE.
- All outputs are registered.
- Tick evaluated in cycle T -> wr_en/rd_en/addresses valid in T+1 for exactly one cycle.
- RAM captures the write and registers the read at the end of T+1. dout_valid is high in T+2, exactly one cycle.
- Sample period = div+1 cycles. With div=0, strobes are continuous every cycle.
- en falling: no tick in that cycle. Strobes already in flight still complete, including dout_valid in T+2.
- Reset asserted mid-operation: all outputs go to 0 immediately (asynchronously). Pending dout_valid is dropped.

## Test plan
- Reset and hold: with rst_n=0 then en=1, ADDR_WIDTH=8, div=3, offset=4 -> wr_en every 4 cycles with wr_addr 0,1,2,...
  - rd_en first appears on the 5th write (wr_addr=4, rd_addr=0). primed rises in the same cycle as that rd_en.
  - dout_valid follows each rd_en by one cycle.
- Wrap-around: run div=0, offset=3 for 300 cycles -> wr_addr wraps 255 -> 0. At wr_addr=1, rd_addr=254.
- Offset zero: offset=0, div=0 -> no rd_en for the first 256 writes. Then rd_addr == wr_addr every cycle, and primed=1.
- Offset change: once in RUN with count=10, set offset 5 -> 20.
  - primed drops and rd_en stops.
  - Both resume on the tick where count reaches 20, with rd_addr = wr_addr - 20.
- Clear and en: pulse clear during RUN -> next write at wr_addr=0 and primed=0.
  - Drop en mid-period -> no strobes and the divider restarts at 0 when en returns.
- Async reset mid-run: assert rst_n=0 between a rd_en and its dout_valid -> all outputs are 0 immediately and no dout_valid appears.

Source files
------------

// File: rtl/delay_addr_gen.sv
// Circular write/read address and strobe generator for the delayed-signal sample RAM.
// Writes one sample per divider tick and reads `offset` samples behind once enough history exists.
module delay_addr_gen #(
  parameter int ADDR_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clear,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [ADDR_WIDTH-1:0] offset,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  dout_valid,
  output logic                  primed
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t                state;
  logic [DIV_WIDTH-1:0]  cnt;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         need;
  logic                  meets;
  logic                  tick;
  logic                  rd_go;

  // cnt >= div (rather than ==) lets the divider recover at once if div shrinks below cnt
  always_comb begin
    need  = (offset == '0) ? DEPTH : {1'b0, offset};
    meets = (count >= need);
    tick  = en && !clear && (cnt >= div);
    rd_go = tick && meets;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !en || (cnt >= div)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      count <= '0;
    end else if (tick) begin
      wptr <= wptr + ADDR_WIDTH'(1);
      if (count != DEPTH) begin
        count <= count + CW'(1);
      end
    end
  end

  // Strobes lag the tick by one cycle; dout_valid follows rd_en by the RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      dout_valid <= 1'b0;
    end else begin
      wr_en      <= tick;
      rd_en      <= rd_go;
      dout_valid <= rd_en;
      if (tick) begin
        wr_addr <= wptr;
      end
      if (rd_go) begin
        rd_addr <= wptr - offset;
      end
    end
  end

  // FILL enters RUN only on the tick that issues the first read, so primed rises with that rd_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      primed <= 1'b0;
    end else if (clear || !en) begin
      state  <= IDLE;
      primed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (meets) begin
            state  <= RUN;
            primed <= 1'b1;
          end else begin
            state  <= FILL;
            primed <= 1'b0;
          end
        end
        FILL: begin
          if (rd_go) begin
            state  <= RUN;
            primed <= 1'b1;
          end
        end
        RUN: begin
          if (!meets) begin
            state  <= FILL;
            primed <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          primed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_addr_gen.sv
// Directed bench for delay_addr_gen: fill/run sequencing, wrap, offset zero/change,
// clear, en drop and asynchronous reset.
module tb_delay_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        clear;
  logic [15:0] div;
  logic [7:0]  offset;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic        dout_valid;
  logic        primed;

  int checks = 0;
  int errors = 0;

  delay_addr_gen #(.ADDR_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clear      (clear),
    .div        (div),
    .offset     (offset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .dout_valid (dout_valid),
    .primed     (primed)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input string tag, input logic [7:0] wa, input logic re,
                             input logic [7:0] ra, input logic pr);
    check_output({tag, " wr_en"}, 32'(wr_en), 32'd1);
    check_output({tag, " wr_addr"}, 32'(wr_addr), 32'(wa));
    check_output({tag, " rd_en"}, 32'(rd_en), 32'(re));
    if (re) check_output({tag, " rd_addr"}, 32'(rd_addr), 32'(ra));
    check_output({tag, " primed"}, 32'(primed), 32'(pr));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    clear = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    clear  = 1'b0;
    div    = 16'd3;
    offset = 8'd4;
    #1;
    check_output("reset wr_en", 32'(wr_en), 32'd0);
    check_output("reset rd_en", 32'(rd_en), 32'd0);
    check_output("reset wr_addr", 32'(wr_addr), 32'd0);
    check_output("reset rd_addr", 32'(rd_addr), 32'd0);
    check_output("reset dout_valid", 32'(dout_valid), 32'd0);
    check_output("reset primed", 32'(primed), 32'd0);

    // div=3, offset=4: a write every 4 cycles, first read on the fifth write
    step(2);
    rst_n = 1'b1;
    en    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(3);
      check_output("period gap wr_en", 32'(wr_en), 32'd0);
      step(1);
      check_write("fill", 8'(k), (k == 4), 8'd0, (k == 4));
    end
    step(1);
    check_output("dv after rd", 32'(dout_valid), 32'd1);
    check_output("rd_en one cycle", 32'(rd_en), 32'd0);
    step(1);
    check_output("dv one cycle", 32'(dout_valid), 32'd0);

    // Async reset between rd_en and its dout_valid
    step(2);
    check_write("pre-reset", 8'd5, 1'b1, 8'd1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async wr_en", 32'(wr_en), 32'd0);
    check_output("async rd_en", 32'(rd_en), 32'd0);
    check_output("async wr_addr", 32'(wr_addr), 32'd0);
    check_output("async rd_addr", 32'(rd_addr), 32'd0);
    check_output("async primed", 32'(primed), 32'd0);
    step(1);
    check_output("async dv dropped", 32'(dout_valid), 32'd0);

    // Wrap-around with div=0, offset=3
    div    = 16'd0;
    offset = 8'd3;
    en     = 1'b1;
    rst_n  = 1'b1;
    step(1);
    check_write("wrap first", 8'd0, 1'b0, 8'd0, 1'b0);
    step(3);
    check_write("wrap first rd", 8'd3, 1'b1, 8'd0, 1'b1);
    step(252);
    check_write("wrap 255", 8'd255, 1'b1, 8'd252, 1'b1);
    step(1);
    check_write("wrap 0", 8'd0, 1'b1, 8'd253, 1'b1);
    step(1);
    check_write("wrap 1", 8'd1, 1'b1, 8'd254, 1'b1);

    // Clear during RUN restarts at address 0, unprimed
    clear = 1'b1;
    step(1);
    check_output("clear wr_en", 32'(wr_en), 32'd0);
    check_output("clear rd_en", 32'(rd_en), 32'd0);
    check_output("clear primed", 32'(primed), 32'd0);
    clear = 1'b0;
    step(1);
    check_write("after clear", 8'd0, 1'b0, 8'd0, 1'b0);

    // Drop en mid-period; the divider must restart from 0
    div = 16'd3;
    step(2);
    en = 1'b0;
    step(1);
    check_output("en low wr_en a", 32'(wr_en), 32'd0);
    step(2);
    check_output("en low wr_en b", 32'(wr_en), 32'd0);
    en = 1'b1;
    step(3);
    check_output("div restart gap", 32'(wr_en), 32'd0);
    step(1);
    check_write("div restart tick", 8'd1, 1'b0, 8'd0, 1'b0);

    // Offset zero: full-buffer delay
    apply_reset();
    div    = 16'd0;
    offset = 8'd0;
    en     = 1'b1;
    step(256);
    check_write("off0 last fill", 8'd255, 1'b0, 8'd0, 1'b0);
    step(1);
    check_write("off0 first rd", 8'd0, 1'b1, 8'd0, 1'b1);
    step(1);
    check_write("off0 second rd", 8'd1, 1'b1, 8'd1, 1'b1);

    // Offset change 5 -> 20 with count=10
    apply_reset();
    div    = 16'd0;
    offset = 8'd5;
    en     = 1'b1;
    step(10);
    check_write("off5 run", 8'd9, 1'b1, 8'd4, 1'b1);
    offset = 8'd20;
    step(1);
    check_write("off20 refill", 8'd10, 1'b0, 8'd0, 1'b0);
    step(9);
    check_write("off20 still fill", 8'd19, 1'b0, 8'd0, 1'b0);
    step(1);
    check_write("off20 resume", 8'd20, 1'b1, 8'd0, 1'b1);
    step(1);
    check_write("off20 next", 8'd21, 1'b1, 8'd1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
